// File: rtl/rv32_scoreboard_if.sv
// Decode/issue and writeback-retire signals shared between the pipeline and the
// register scoreboard. The pipeline side uses the master modport and the scoreboard uses the slave modport.
interface rv32_scoreboard_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [1:0] id_use_rs;
  logic [4:0] id_rd;
  logic       id_wb;
  logic       id_long;
  logic       issue_ready;
  logic       wb_valid;
  logic [4:0] wb_rd;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs, id_rd, id_wb, id_long,
    output wb_valid, wb_rd,
    input  issue_ready
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs, id_rd, id_wb, id_long,
    input  wb_valid, wb_rd,
    output issue_ready
  );
endinterface

// File: rtl/rv32_scoreboard.sv
// Register scoreboard that tracks long-latency writes to x1..x31 and stalls decode on RAW, WAW-overflow and outstanding-limit hazards.
// The optional stall counters are built when RV32_SCOREBOARD_PERF_EN is defined.
module rv32_scoreboard #(
  parameter  int CNT_W           = 2,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int WB_BYPASS       = 1,
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  rv32_scoreboard_if.slave     sb,
  output logic [31:0]          pending,
  output logic [OUT_W-1:0]     outstanding,
  output logic                 sb_err
`ifdef RV32_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          raw_stalls
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt [32];

  logic retire;
  logic long_wr;
  logic haz_rs1;
  logic haz_rs2;
  logic waw_full;
  logic out_full;
  logic ready;
  logic alloc;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    retire  = sb.wb_valid && (sb.wb_rd != 5'd0);
    long_wr = sb.id_wb && sb.id_long && (sb.id_rd != 5'd0);

    haz_rs1 = sb.id_use_rs[0] && (sb.id_rs1 != 5'd0) && (cnt[sb.id_rs1] != '0);
    haz_rs2 = sb.id_use_rs[1] && (sb.id_rs2 != 5'd0) && (cnt[sb.id_rs2] != '0);
    // A retire of the last pending write to a source releases that source in the same cycle.
    if (WB_BYPASS != 0) begin
      if (retire && (sb.wb_rd == sb.id_rs1) && (cnt[sb.id_rs1] == CNT_W'(1))) haz_rs1 = 1'b0;
      if (retire && (sb.wb_rd == sb.id_rs2) && (cnt[sb.id_rs2] == CNT_W'(1))) haz_rs2 = 1'b0;
    end

    waw_full = long_wr && (cnt[sb.id_rd] == CNT_MAX);
    out_full = long_wr && (outstanding == OUT_W'(MAX_OUTSTANDING)) && !retire;
    ready    = !haz_rs1 && !haz_rs2 && !waw_full && !out_full;
    alloc    = sb.id_valid && ready && long_wr;
  end

  assign sb.issue_ready = ready;

  always_comb begin
    pending = '0;
    for (int r = 1; r < 32; r++) pending[r] = (cnt[r] != '0);
  end

  // NOTE: the counter array is control state, not data storage, so every entry is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
      outstanding <= '0;
      sb_err      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      for (int r = 1; r < 32; r++) begin
        if (alloc && (sb.id_rd == 5'(r)) && !(retire && (sb.wb_rd == 5'(r)))) begin
          cnt[r] <= cnt[r] + CNT_W'(1);
        end else if (retire && (sb.wb_rd == 5'(r)) && !(alloc && (sb.id_rd == 5'(r)))) begin
          if (cnt[r] != '0) cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end

      if (alloc && !retire) begin
        outstanding <= outstanding + OUT_W'(1);
      end else if (retire && !alloc && (outstanding != '0)) begin
        outstanding <= outstanding - OUT_W'(1);
      end

      if (retire && ((cnt[sb.wb_rd] == '0) || (outstanding == '0))) sb_err <= 1'b1;
    end
  end

`ifdef RV32_SCOREBOARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      raw_stalls   <= '0;
    end else if (sb.id_valid && !ready) begin
      stall_cycles <= stall_cycles + 32'd1;
      if (haz_rs1 || haz_rs2) raw_stalls <= raw_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_scoreboard.sv
// Directed self-checking bench for rv32_scoreboard (CNT_W=2, MAX_OUTSTANDING=4, WB_BYPASS=1).
// Stall-counter checks are compiled in when RV32_SCOREBOARD_PERF_EN is defined.
module tb_rv32_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pending;
  logic [2:0]  outstanding;
  logic        sb_err;
`ifdef RV32_SCOREBOARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] raw_stalls;
`endif

  int tests = 0;
  int fails = 0;

  rv32_scoreboard_if bus ();

  rv32_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .sb          (bus.slave),
    .pending     (pending),
    .outstanding (outstanding),
    .sb_err      (sb_err)
`ifdef RV32_SCOREBOARD_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .raw_stalls  (raw_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [1:0] use_rs, input logic [4:0] rd,
                          input logic wb, input logic lng);
    bus.id_valid  = v;
    bus.id_rs1    = rs1;
    bus.id_rs2    = rs2;
    bus.id_use_rs = use_rs;
    bus.id_rd     = rd;
    bus.id_wb     = wb;
    bus.id_long   = lng;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] rd);
    bus.wb_valid = v;
    bus.wb_rd    = rd;
  endtask

  task automatic idle();
    drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    drive_wb(1'b0, 5'd0);
  endtask

  task automatic long_write(input logic [4:0] rd);
    drive_id(1'b1, 5'd0, 5'd0, 2'b00, rd, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    cyc();
    do_reset();
    settle();
    check("reset_pending", pending, 32'h0);
    check("reset_outstanding", 32'(outstanding), 32'd0);
    check("reset_issue_ready", 32'(bus.issue_ready), 32'd1);
    check("reset_sb_err", 32'(sb_err), 32'd0);

    // Load to x5, then RAW on rs1 released by same-cycle retire.
    long_write(5'd5);
    settle();
    check("load_x5_ready", 32'(bus.issue_ready), 32'd1);
    cyc();
    drive_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    settle();
    check("x5_pending", pending, 32'h0000_0020);
    check("x5_outstanding", 32'(outstanding), 32'd1);
    check("raw_rs1_stall", 32'(bus.issue_ready), 32'd0);
    drive_id(1'b1, 5'd5, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    settle();
    check("unused_rs1_no_stall", 32'(bus.issue_ready), 32'd1);
    drive_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    drive_wb(1'b1, 5'd5);
    settle();
    check("raw_bypass_ready", 32'(bus.issue_ready), 32'd1);
    cyc();
    idle();
    settle();
    check("x5_cleared_pending", pending, 32'h0);
    check("x5_cleared_outstanding", 32'(outstanding), 32'd0);

    // Two writes in flight: a retire of one does not release rs2.
    long_write(5'd5);
    cyc();
    cyc();
    drive_id(1'b1, 5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0);
    drive_wb(1'b1, 5'd5);
    settle();
    check("raw_rs2_cnt2_no_bypass", 32'(bus.issue_ready), 32'd0);
    cyc();
    settle();
    check("raw_rs2_cnt1_bypass", 32'(bus.issue_ready), 32'd1);
    cyc();
    idle();
    settle();
    check("x5_drained_pending", pending, 32'h0);
    check("x5_drained_sb_err", 32'(sb_err), 32'd0);

    // WAW overflow on x7.
    long_write(5'd7);
    cyc();
    cyc();
    cyc();
    settle();
    check("x7_pending", pending, 32'h0000_0080);
    check("x7_outstanding", 32'(outstanding), 32'd3);
    check("waw_full_stall", 32'(bus.issue_ready), 32'd0);
    cyc();
    check("waw_full_still_stall", 32'(bus.issue_ready), 32'd0);
    drive_wb(1'b1, 5'd7);
    settle();
    check("waw_full_retire_same_cycle", 32'(bus.issue_ready), 32'd0);
    cyc();
    drive_wb(1'b0, 5'd0);
    settle();
    check("waw_after_retire_outstanding", 32'(outstanding), 32'd2);
    check("waw_after_retire_ready", 32'(bus.issue_ready), 32'd1);
    cyc();
    settle();
    check("waw_refilled_stall", 32'(bus.issue_ready), 32'd0);
    check("waw_refilled_outstanding", 32'(outstanding), 32'd3);
    idle();
    drive_wb(1'b1, 5'd7);
    cyc();
    cyc();
    cyc();
    idle();
    settle();
    check("x7_drained_pending", pending, 32'h0);
    check("x7_drained_outstanding", 32'(outstanding), 32'd0);

    // Outstanding limit.
    long_write(5'd1); cyc();
    long_write(5'd2); cyc();
    long_write(5'd3); cyc();
    long_write(5'd4); cyc();
    long_write(5'd9);
    settle();
    check("limit_outstanding", 32'(outstanding), 32'd4);
    check("limit_pending", pending, 32'h0000_001E);
    check("limit_stall", 32'(bus.issue_ready), 32'd0);
    drive_wb(1'b1, 5'd2);
    settle();
    check("limit_retire_ready", 32'(bus.issue_ready), 32'd1);
    cyc();
    idle();
    settle();
    check("limit_swap_outstanding", 32'(outstanding), 32'd4);
    check("limit_swap_pending", pending, 32'h0000_021A);
    drive_wb(1'b1, 5'd1); cyc();
    drive_wb(1'b1, 5'd3); cyc();
    drive_wb(1'b1, 5'd4); cyc();
    drive_wb(1'b1, 5'd9); cyc();
    idle();
    settle();
    check("limit_drained_outstanding", 32'(outstanding), 32'd0);
    check("limit_drained_sb_err", 32'(sb_err), 32'd0);

    // x0 handling and error on spurious retire.
    long_write(5'd0);
    drive_wb(1'b1, 5'd0);
    settle();
    check("x0_ready", 32'(bus.issue_ready), 32'd1);
    cyc();
    idle();
    settle();
    check("x0_pending", pending, 32'h0);
    check("x0_outstanding", 32'(outstanding), 32'd0);
    check("x0_sb_err", 32'(sb_err), 32'd0);
    drive_wb(1'b1, 5'd12);
    cyc();
    idle();
    settle();
    check("spurious_sb_err", 32'(sb_err), 32'd1);
    check("spurious_outstanding_sat", 32'(outstanding), 32'd0);
    check("spurious_pending", pending, 32'h0);
    cyc();
    cyc();
    check("sticky_sb_err", 32'(sb_err), 32'd1);

    // Reset mid-operation discards in-flight state.
    long_write(5'd6);
    cyc();
    do_reset();
    settle();
    check("midrst_sb_err", 32'(sb_err), 32'd0);
    check("midrst_pending", pending, 32'h0);
    check("midrst_outstanding", 32'(outstanding), 32'd0);
    drive_wb(1'b1, 5'd6);
    cyc();
    idle();
    settle();
    check("stale_retire_sb_err", 32'(sb_err), 32'd1);
    do_reset();

`ifdef RV32_SCOREBOARD_PERF_EN
    long_write(5'd5);
    cyc();
    drive_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    cyc();
    cyc();
    cyc();
    idle();
    settle();
    check("perf_raw_stall_cycles", stall_cycles, 32'd3);
    check("perf_raw_raw_stalls", raw_stalls, 32'd3);
    long_write(5'd1); cyc();
    long_write(5'd2); cyc();
    long_write(5'd3); cyc();
    long_write(5'd9);
    cyc();
    cyc();
    idle();
    settle();
    check("perf_limit_stall_cycles", stall_cycles, 32'd5);
    check("perf_limit_raw_stalls", raw_stalls, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rv32_scoreboard.md
Name: rv32_scoreboard

Overview:
- Register scoreboard between decode and issue.
- Tracks in-flight writes from long-latency units (load, MUL, GRNG) to x1..x31.
- Stalls decode on RAW hazards against those writes, on per-register write-after-write (WAW) overflow, and on global outstanding-limit overflow.
- Fed by the decoder's rs/rd usage flags and by the writeback stage's retire port.

Parameters:
- CNT_W, 2, width of per-register in-flight counter; max per-register in-flight = 2^CNT_W-1.
- MAX_OUTSTANDING, 4, max total long-latency writes in flight across all registers (1..31).
- WB_BYPASS, 1, 1 = a same-cycle retire of the last pending write to a source register clears that hazard in the same cycle.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  decode holds a valid instruction
- id_rs1  in  5  source register 1 index
- id_rs2  in  5  source register 2 index
- id_use_rs  in  2  [0]=rs1 used, [1]=rs2 used (from decoder)
- id_rd  in  5  destination register index
- id_wb  in  1  instruction writes rd
- id_long  in  1  writeback comes from a long-latency unit (WB_MEM_DATA, WB_MUL_UNIT, WB_GRNG)
- issue_ready  out  1  decode may issue this cycle
- wb_valid  in  1  a long-latency write retires this cycle
- wb_rd  in  5  register retired
- pending  out  32  bit r = cnt[r]!=0; bit 0 always 0
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  total in-flight count
- sb_err  out  1  sticky protocol error

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: all cnt[r]=0, outstanding=0, sb_err=0. With reset and issue inputs held idle, pending=0 and issue_ready=1 in the cycle after rst is sampled.
- Definitions:
  - alloc = id_valid & issue_ready & id_wb & id_long & (id_rd!=0).
  - retire = wb_valid & (wb_rd!=0).
  - issue fires = id_valid & issue_ready.
- Counter update, registered next edge:
  - cnt[id_rd] += alloc; cnt[wb_rd] -= retire.
  - Same register, both events: cnt unchanged.
  - outstanding += alloc - retire; both events leaves it unchanged.
- Hazard on src s (s=rs1/rs2, gated by id_use_rs):
  - hazard when s!=0 and cnt[s]!=0.
  - If WB_BYPASS=1: no hazard when retire & wb_rd==s & cnt[s]==1.
- issue_ready, combinational from current state and inputs:
  - issue_ready = !haz_rs1 & !haz_rs2 & !(long_wr & cnt[id_rd]==MAX) & !(long_wr & outstanding==MAX_OUTSTANDING & !retire).
  - long_wr = id_wb & id_long & id_rd!=0.
  - MAX = 2^CNT_W-1.
  - issue_ready does not depend on id_valid; it is valid every cycle.
- Short-latency writes (id_long=0): no allocation and no WAW check. In-order pipeline forwarding covers them.
- Error cases: retire with cnt[wb_rd]==0 or outstanding==0 sets sb_err (sticky until rst). cnt and outstanding saturate at 0.
- x0: never allocated; retire to x0 ignored, no error.
- Reset mid-operation: all in-flight state discarded. Retires arriving in later cycles for pre-reset allocations raise sb_err. The pipeline must flush units together with rst.
- No internal pipelining: hazard decision in the cycle presented, state visible the next cycle.

Optional Feature:
- Macro: RV32_SCOREBOARD_PERF_EN.
- Defined:
  - Adds outputs stall_cycles (32) and raw_stalls (32).
  - stall_cycles increments every cycle with id_valid & !issue_ready.
  - raw_stalls increments when the stall is due to haz_rs1|haz_rs2.
  - Both reset to 0 on rst and wrap at 2^32.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then idle -> pending=0, outstanding=0, issue_ready=1, sb_err=0.
- Issue load rd=5 (long); next cycle id_use_rs=01, rs1=5 -> issue_ready=0. Assert wb_valid, wb_rd=5 the same cycle -> issue_ready=1 (WB_BYPASS=1); following cycle pending[5]=0.
- Issue 3 long writes to x7 back to back (CNT_W=2) -> cnt[7]=3. A 4th long write to x7 -> issue_ready=0 until one retire; then the issue fires, cnt[7]=3.
- Allocate x1..x4 (MAX_OUTSTANDING=4) -> outstanding=4. Long write to x9 -> stall. Same cycle with wb_valid, wb_rd=2 -> issue fires, outstanding stays 4.
- Long write to rd=0 and retire to x0 -> no pending bit, outstanding unchanged, sb_err=0. Retire x12 with cnt[12]=0 -> sb_err=1 and stays 1 until rst.
- With RV32_SCOREBOARD_PERF_EN: 3-cycle RAW stall -> stall_cycles=3, raw_stalls=3. 2-cycle outstanding-limit stall -> stall_cycles=5, raw_stalls=3.
